// File: rtl/multiword_add_sequencer_pkg.sv
// multiword_add_sequencer_pkg: shared FSM state type and slice width for the multiword adder.
package multiword_add_sequencer_pkg;
   localparam int SLICE_W = 8;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: SLICE_W-bit ripple-carry adder slice shared across all words.
module ripple_carry_adder
   import multiword_add_sequencer_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);
   logic [SLICE_W:0] w_c;
   assign w_c[0] = cin;
   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end
   assign cout = w_c[SLICE_W];
endmodule

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: runs one 8-bit adder slice over WORDS cycles for a wide add/subtract,
// carrying between slices through a flop; valid/ready on both sides.
module multiword_add_sequencer
   import multiword_add_sequencer_pkg::*;
#(
   parameter int WORDS = 4,
   localparam int W    = SLICE_W * WORDS,
   localparam int IW   = $clog2(WORDS)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         cout,
   output logic         ovf,
   output logic         zero
);
   state_t             r_state;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic [W-1:0]       r_res;
   logic               r_carry;
   logic [IW-1:0]      r_idx;
   logic               r_cout;
   logic               r_ovf;
   logic               r_out_valid;
   logic [SLICE_W-1:0] w_sum;
   logic               w_cout;
   logic               w_last;

   ripple_carry_adder u_rca (
      .a    (r_a[SLICE_W-1:0]),
      .b    (r_b[SLICE_W-1:0]),
      .cin  (r_carry),
      .sum  (w_sum),
      .cout (w_cout)
   );

   assign w_last    = r_idx == IW'(WORDS - 1);
   assign in_ready  = r_state == IDLE;
   assign out_valid = r_out_valid;
   assign result    = r_res;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = ~|r_res;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_res       <= '0;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_a     <= a;
               r_b     <= sub ? ~b : b;
               r_carry <= sub;
               r_idx   <= '0;
               r_state <= RUN;
            end
            RUN: begin
               r_a     <= r_a >> SLICE_W;
               r_b     <= r_b >> SLICE_W;
               r_res   <= {w_sum, r_res[W-1:SLICE_W]};
               r_carry <= w_cout;
               r_idx   <= r_idx + IW'(1);
               // top slice: signs of a and post-invert b agree but the sum sign differs
               if (w_last) begin
                  r_ovf   <= (r_a[SLICE_W-1] == r_b[SLICE_W-1]) && (w_sum[SLICE_W-1] != r_a[SLICE_W-1]);
                  r_cout  <= w_cout;
                  r_idx   <= '0;
                  r_state <= DONE;
               end
            end
            DONE: begin
               // out_valid is registered, so it rises one edge after DONE entry
               if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end else begin
                  r_out_valid <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: directed vectors with hand-computed results for WORDS=4.
module tb_multiword_add_sequencer;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        cout;
   logic        ovf;
   logic        zero;
   int          n_tests;
   int          n_fail;

   multiword_add_sequencer #(.WORDS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic accept(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input string tag);
      @(negedge clk);
      a = ta; b = tb; sub = ts; in_valid = 1'b1;
      check({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; sub = ~ts;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_latency"}, n, 5);
   endtask

   task automatic check_out(input string tag, input logic [31:0] er, input logic ec, input logic eo, input logic ez);
      check({tag, "_result"}, result, er);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_ovf"}, ovf, eo);
      check({tag, "_zero"}, zero, ez);
      check({tag, "_busy"}, in_ready, 0);
   endtask

   task automatic drain(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_ov_drop"}, out_valid, 0);
      check({tag, "_idle"}, in_ready, 1);
   endtask

   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                         input logic [31:0] er, input logic ec, input logic eo, input logic ez, input string tag);
      accept(ta, tb, ts, tag);
      wait_done(tag);
      check_out(tag, er, ec, eo, ez);
      drain(tag);
   endtask

   initial begin
      int seen;
      n_tests = 0; n_fail = 0;
      clk = 0; rst = 1; in_valid = 0; a = 0; b = 0; sub = 0; out_ready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_zero", zero, 1);
      check("rst_flags", {cout, ovf}, 0);

      run_op(32'h0000_00FF, 32'h0000_0001, 0, 32'h0000_0100, 0, 0, 0, "carry_chain");
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1, 0, 1, "wrap");
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 0, 1, 0, "pos_ovf");
      run_op(32'h0000_0005, 32'h0000_0007, 1, 32'hFFFF_FFFE, 0, 0, 0, "sub_borrow");
      run_op(32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 1, 1, 0, "sub_ovf");

      accept(32'h1234_5678, 32'h1111_1111, 0, "bp");
      wait_done("bp");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = ~a; b = b + 32'h55; in_valid = ~in_valid;
         @(posedge clk);
         #1;
         check("bp_hold_valid", out_valid, 1);
         check_out("bp_hold", 32'h2345_6789, 0, 0, 0);
      end
      in_valid = 0;
      drain("bp");
      run_op(32'h0000_0003, 32'h0000_0003, 1, 32'h0000_0000, 1, 0, 1, "after_bp");

      accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mid_rst");
      @(posedge clk);
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_result", result, 0);
      check("mid_rst_zero", zero, 1);
      @(negedge clk);
      rst = 0;
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("mid_rst_no_stale", seen, 0);
      run_op(32'h0101_0101, 32'h0202_0202, 0, 32'h0303_0303, 0, 0, 0, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
